sme_stim_driver: RTL and testbench

//  Transmit-side driver for the string-matching engine (SME) byte protocol.
//  A host loads a string (<=32 B) and a pattern (<=8 B) into local buffers, then pulses start.
//  The block streams the bytes on chardata/isstring/ispattern, waits for the engine's

---
 rtl/sme_stim_driver_if.sv | 19 +
 rtl/sme_stim_driver.sv | 193 +++++++++++++++++++
 tb/tb_sme_stim_driver.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sme_stim_driver_if.sv
// Byte bus between the stimulus driver and the string-matching engine.
interface sme_stim_driver_if;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  modport master (
    output chardata, isstring, ispattern,
    input  valid, match, match_index
  );

  modport slave (
    input  chardata, isstring, ispattern,
    output valid, match, match_index
  );
endinterface

// File: rtl/sme_stim_driver.sv
// Loads string/pattern buffers from the host, streams them to the SME and returns one result.
module sme_stim_driver #(
  parameter int unsigned STR_DEPTH = 32,
  parameter int unsigned PAT_DEPTH = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       clr,
  input  logic       start,
  input  logic       reuse_str,
  output logic       busy,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       err,
  sme_stim_driver_if.master sme
);

  localparam int unsigned SLW = $clog2(STR_DEPTH + 1);
  localparam int unsigned PLW = $clog2(PAT_DEPTH + 1);
  localparam int unsigned SAW = $clog2(STR_DEPTH);
  localparam int unsigned PAW = $clog2(PAT_DEPTH);
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND_S, SEND_P, WAIT, REPORT} state_t;

  state_t         state, state_d;
  logic [SLW-1:0] idx, idx_d;
  logic [SLW-1:0] s_len, s_len_d, s_base;
  logic [PLW-1:0] p_len, p_len_d, p_base;
  logic [CW-1:0]  cnt, cnt_d;
  logic           err_d, res_match_d, res_timeout_d;
  logic [4:0]     res_index_d;
  logic           s_we, p_we;
  logic [SAW-1:0] s_waddr;
  logic [PAW-1:0] p_waddr;
  logic [7:0]     chardata_d;
  logic           isstring_d, ispattern_d;

  logic [7:0] str_mem [STR_DEPTH];
  logic [7:0] pat_mem [PAT_DEPTH];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state, buffer bookkeeping and next values of the registered outputs
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    cnt_d         = cnt;
    s_len_d       = s_len;
    p_len_d       = p_len;
    s_base        = s_len;
    p_base        = p_len;
    err_d         = err;
    res_match_d   = res_match;
    res_index_d   = res_index;
    res_timeout_d = res_timeout;
    s_we          = 1'b0;
    p_we          = 1'b0;
    s_waddr       = '0;
    p_waddr       = '0;

    case (state)
      IDLE: begin
        if (start) begin
          if (p_len != '0 && (reuse_str || s_len != '0)) begin
            state_d = reuse_str ? SEND_P : SEND_S;
            idx_d   = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        // clr acts before a same-cycle write so the byte lands at index 0
        if (!wr_sel) begin
          s_base  = clr ? '0 : s_len;
          s_len_d = s_base;
          if (wr_en) begin
            if (s_base == SLW'(STR_DEPTH)) begin
              err_d = 1'b1;
            end else begin
              s_we    = 1'b1;
              s_waddr = s_base[SAW-1:0];
              s_len_d = SLW'(s_base + 1'b1);
            end
          end
        end else begin
          p_base  = clr ? '0 : p_len;
          p_len_d = p_base;
          if (wr_en) begin
            if (p_base == PLW'(PAT_DEPTH)) begin
              err_d = 1'b1;
            end else begin
              p_we    = 1'b1;
              p_waddr = p_base[PAW-1:0];
              p_len_d = PLW'(p_base + 1'b1);
            end
          end
        end
      end
      SEND_S: begin
        if (SLW'(idx + 1'b1) == s_len) begin
          state_d = SEND_P;
          idx_d   = '0;
        end else begin
          idx_d = SLW'(idx + 1'b1);
        end
      end
      SEND_P: begin
        if (SLW'(idx + 1'b1) == SLW'(p_len)) begin
          state_d = WAIT;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          idx_d = SLW'(idx + 1'b1);
        end
      end
      WAIT: begin
        // A valid arriving in the last allowed cycle still gives a normal result
        if (sme.valid) begin
          state_d       = REPORT;
          res_match_d   = sme.match;
          res_index_d   = sme.match_index;
          res_timeout_d = 1'b0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d       = REPORT;
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
        end else begin
          cnt_d = CW'(cnt + 1'b1);
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    isstring_d  = (state_d == SEND_S);
    ispattern_d = (state_d == SEND_P);
    if (isstring_d)       chardata_d = str_mem[idx_d[SAW-1:0]];
    else if (ispattern_d) chardata_d = pat_mem[idx_d[PAW-1:0]];
    else                  chardata_d = 8'h00;
  end

  // Buffer storage; contents survive reset, only the lengths are cleared
  always_ff @(posedge clk) begin
    if (s_we) str_mem[s_waddr] <= wr_data;
    if (p_we) pat_mem[p_waddr] <= wr_data;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      cnt           <= '0;
      s_len         <= '0;
      p_len         <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res_match     <= 1'b0;
      res_index     <= '0;
      res_timeout   <= 1'b0;
      sme.chardata  <= '0;
      sme.isstring  <= 1'b0;
      sme.ispattern <= 1'b0;
    end else begin
      idx           <= idx_d;
      cnt           <= cnt_d;
      s_len         <= s_len_d;
      p_len         <= p_len_d;
      err           <= err_d;
      busy          <= (state_d != IDLE);
      res_valid     <= (state_d == REPORT);
      res_match     <= res_match_d;
      res_index     <= res_index_d;
      res_timeout   <= res_timeout_d;
      sme.chardata  <= chardata_d;
      sme.isstring  <= isstring_d;
      sme.ispattern <= ispattern_d;
    end
  end

endmodule

// File: tb/tb_sme_stim_driver.sv
// Directed bench for sme_stim_driver: job table plus hand-written corner sequences.
module tb_sme_stim_driver;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_sel, clr, start, reuse_str;
  logic [7:0] wr_data;
  logic       busy, res_valid, res_match, res_timeout, err;
  logic [4:0] res_index;

  int n_chk  = 0;
  int n_fail = 0;

  sme_stim_driver_if bus ();

  sme_stim_driver #(.STR_DEPTH(32), .PAT_DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .clr(clr), .start(start), .reuse_str(reuse_str), .busy(busy),
    .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
    .res_timeout(res_timeout), .err(err), .sme(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    s;       // string contents expected on the bus (loaded unless load=0/reuse)
    string    p;       // pattern contents
    bit       load;
    bit       reuse;
    bit       noise;   // drive stray valid during the send phases
    int       delay;   // WAIT cycle in which the engine raises valid, -1 = never
    bit       m;
    bit [4:0] mi;
    bit       exp_m;
    bit [4:0] exp_i;
    bit       exp_to;
  } vec_t;

  function automatic vec_t mk(string s, string p, bit load, bit reuse, bit noise, int delay,
                              bit m, bit [4:0] mi, bit exp_m, bit [4:0] exp_i, bit exp_to);
    vec_t v;
    v.s = s; v.p = p; v.load = load; v.reuse = reuse; v.noise = noise; v.delay = delay;
    v.m = m; v.mi = mi; v.exp_m = exp_m; v.exp_i = exp_i; v.exp_to = exp_to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_buf(input bit sel);
    wr_sel = sel; clr = 1'b1;
    tick;
    clr = 1'b0;
  endtask

  task automatic load_buf(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) begin
      wr_en = 1'b1; wr_sel = sel; wr_data = s[i]; clr = (i == 0);
      tick;
    end
    wr_en = 1'b0; clr = 1'b0;
    if (s.len() == 0) clear_buf(sel);
  endtask

  // Launch one job and check every bus cycle through the result strobe
  task automatic run_job(input string tag, input vec_t v);
    int es, ws, rc;
    bit real_v;
    es = v.reuse ? 0 : v.s.len();
    ws = es + v.p.len();
    rc = ws + ((v.delay >= 0) ? v.delay + 1 : TIMEOUT);
    if (v.load) begin
      if (!v.reuse) load_buf(1'b0, v.s);
      load_buf(1'b1, v.p);
    end
    start = 1'b1; reuse_str = v.reuse;
    tick;
    start = 1'b0; reuse_str = 1'b0;
    chk({tag, " err_cleared"}, 32'(err), 32'd0);
    for (int c = 0; c <= rc; c++) begin
      logic [7:0] exp_cd;
      bit exp_is, exp_ip;
      exp_is = (c < es);
      exp_ip = (c >= es) && (c < ws);
      exp_cd = exp_is ? v.s[c] : (exp_ip ? v.p[c - es] : 8'h00);
      chk($sformatf("%s isstring c%0d", tag, c), 32'(bus.isstring), 32'(exp_is));
      chk($sformatf("%s ispattern c%0d", tag, c), 32'(bus.ispattern), 32'(exp_ip));
      chk($sformatf("%s chardata c%0d", tag, c), 32'(bus.chardata), 32'(exp_cd));
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s res_valid c%0d", tag, c), 32'(res_valid), 32'(c == rc));
      if (c == rc) begin
        chk({tag, " res_match"}, 32'(res_match), 32'(v.exp_m));
        chk({tag, " res_index"}, 32'(res_index), 32'(v.exp_i));
        chk({tag, " res_timeout"}, 32'(res_timeout), 32'(v.exp_to));
      end
      real_v = (v.delay >= 0) && (c == ws + v.delay);
      bus.valid       = real_v || (v.noise && c < ws);
      bus.match       = real_v ? v.m : ~v.m;
      bus.match_index = real_v ? v.mi : ~v.mi;
      tick;
    end
    bus.valid = 1'b0; bus.match = 1'b0; bus.match_index = '0;
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " res_valid_after"}, 32'(res_valid), 32'd0);
    chk({tag, " res_index_held"}, 32'(res_index), 32'(v.exp_i));
  endtask

  vec_t vecs[6];
  string s32;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0; clr = 1'b0;
    start = 1'b0; reuse_str = 1'b0;
    bus.valid = 1'b0; bus.match = 1'b0; bus.match_index = '0;
    s32 = "abcdefghijklmnopqrstuvwxyz012345";

    vecs[0] = mk("ab cd", "cd",  1, 0, 0,   2, 1, 5'd3,  1, 5'd3,  0);
    vecs[1] = mk("",      "^ab", 1, 1, 0,   0, 1, 5'd0,  1, 5'd0,  0);
    vecs[2] = mk("hello", "xyz", 1, 0, 1,   5, 0, 5'd7,  0, 5'd7,  0);
    vecs[3] = mk("q",     "q",   1, 0, 0,   0, 1, 5'd31, 1, 5'd31, 0);
    vecs[4] = mk("abc",   "b",   1, 0, 0,  -1, 1, 5'd9,  0, 5'd0,  1);
    vecs[5] = mk("abc",   "b",   0, 0, 0, 254, 1, 5'd2,  1, 5'd2,  0);

    repeat (2) tick;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset isstring", 32'(bus.isstring), 32'd0);
    chk("reset ispattern", 32'(bus.ispattern), 32'd0);
    chk("reset chardata", 32'(bus.chardata), 32'd0);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 6; i++) run_job($sformatf("job%0d", i), vecs[i]);

    // String overflow: 33rd byte dropped, err sticky until an accepted start
    load_buf(1'b0, s32);
    chk("ovf_s err_before", 32'(err), 32'd0);
    load_buf(1'b0, {s32, "6"});
    chk("ovf_s err_set", 32'(err), 32'd1);
    load_buf(1'b1, "Z");
    chk("ovf_s err_sticky", 32'(err), 32'd1);
    run_job("ovf_s", mk(s32, "Z", 0, 0, 0, 1, 1, 5'd4, 1, 5'd4, 0));

    // Pattern overflow: 9th byte dropped
    load_buf(1'b1, "ABCDEFGHI");
    chk("ovf_p err_set", 32'(err), 32'd1);
    run_job("ovf_p", mk(s32, "ABCDEFGH", 0, 0, 0, 0, 0, 5'd1, 0, 5'd1, 0));

    // Start with an empty pattern is rejected
    clear_buf(1'b1);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("nopat busy c%0d", c), 32'(busy), 32'd0);
      chk($sformatf("nopat bus c%0d", c), 32'({bus.isstring, bus.ispattern}), 32'd0);
      chk($sformatf("nopat err c%0d", c), 32'(err), 32'd1);
      tick;
    end

    // Reset in the middle of the string phase
    load_buf(1'b0, "hello");
    load_buf(1'b1, "lo");
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("rst_mid isstring_before", 32'(bus.isstring), 32'd1);
    chk("rst_mid chardata_before", 32'(bus.chardata), 32'h65);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst_mid isstring", 32'(bus.isstring), 32'd0);
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid res_valid", 32'(res_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk($sformatf("rst_mid idle c%0d", c), 32'({busy, res_valid, bus.ispattern}), 32'd0);
    end
    load_buf(1'b1, "x");
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("rst_mid slen0 busy", 32'(busy), 32'd0);
    chk("rst_mid slen0 isstring", 32'(bus.isstring), 32'd0);
    chk("rst_mid slen0 err", 32'(err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
